stepper_axis_ctrl: RTL and testbench
====================================

# stepper_axis_ctrl

Parametrised unipolar stepper-motor axis controller: debounced-free, synchronised active-low jog buttons and end-of-travel switches drive a direction FSM, a programmable step-rate divider, and a full/half-step phase sequencer with a signed position counter. It is the next-generation replacement for the fixed-rate, full-step-only axis controller. It sits between the board push-buttons/limit switches and the coil driver pins.

## Interface
- CLK_HZ, 50_000_000, system clock frequency.
- STEP_HZ, 500, step rate; DIV = CLK_HZ/STEP_HZ (integer, must be ≥ 2).
- POS_W, 16, position counter width.
- HOLD_EN, 1, 1 = coils keep last phase when idle; 0 = step_out forced to 4'b0000 when idle.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_Up  in  1  jog up, active-low, asynchronous to clk.
- btn_Down  in  1  jog down, active-low, asynchronous.
- stop_Up  in  1  upper limit switch, active-low, asynchronous.
- stop_Down  in  1  lower limit switch, active-low, asynchronous.
- half_mode  in  1  1 = half-step sequence, 0 = full-step (sampled only in IDLE).
- step_out  out  4  coil drive A,B,C,D.
- moving  out  1  high in UP or DOWN.
- dir  out  1  1 = up, 0 = down; last commanded direction.
- position  out  POS_W  signed step count, two's complement.

## Operation
- All four active-low inputs pass through 2-FF synchronisers; internal signals are active-high after sync (up_req, dn_req, lim_up, lim_dn).
- FSM states: IDLE, UP, DOWN.
  - IDLE → UP: up_req & ~dn_req & ~lim_up. IDLE → DOWN: dn_req & ~up_req & ~lim_dn.
  - UP → IDLE: ~up_req or dn_req or lim_up. DOWN symmetric.
  - Both requests active → IDLE (no motion). Direct UP↔DOWN transition never happens; passes through IDLE for ≥1 cycle.
- Divider: counter 0..DIV-1, cleared in IDLE; tick when counter = DIV-1 in UP/DOWN, then wraps to 0.
- On tick: phase index +1 (UP) or −1 (DOWN), modulo sequence length; position ±1 (wraps modulo 2^POS_W).
- Full-step sequence (index 0..3): 1100, 0110, 0011, 1001.
- Half-step sequence (index 0..7): 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Mode latch: half_mode captured on every IDLE cycle; on full→half switch index maps i→2i+1; on half→full, i→i>>1. Position unit is always one emitted step.
- Limit asserted mid-interval: transition to IDLE, no further tick, pending partial interval discarded.
- Reset: state IDLE, index 0, mode latch = full, divider 0, position 0, step_out 4'b0000, moving 0, dir 1.

## Timing
- step_out, moving, dir, position all registered.
- Input edge → FSM state change: 3 clk (2 sync + 1 state reg).
- First tick DIV clk after entering UP/DOWN; step_out/position update 1 clk after tick (registered), i.e. same edge the index updates.
- moving rises the cycle state enters UP/DOWN; falls the cycle state enters IDLE.
- step_out before first move after reset: 0000; after first move with HOLD_EN=1 it holds last phase in IDLE.
- Reset assertion mid-step clears all outputs immediately (asynchronous); deassertion synchronous to clk behaviour via standard release.

## Configuration
- STEPPER_HALFSTEP_EN defined: half-step table, mode latch and index remap compiled in; half_mode honoured.
- Undefined: half_mode port present but ignored; index 2 bits; full-step only.

## Structure
- Package stepper_pkg: state enum (IDLE, UP, DOWN), full-step and half-step phase constants, DIV computation function.
- Sub-module sync_2ff (1-bit, reset value 1 for active-low inputs), instantiated four times.

## Test plan
Bench parameters CLK_HZ=1000, STEP_HZ=100 (DIV=10), POS_W=8, HOLD_EN=1.
- Reset then btn_Up=0 for 45 clk → 4 steps: step_out 0110,0011,1001,1100; position=4; moving=1 then 0.
- btn_Down=0 for 25 clk from position 4 → position 2, dir=0, step_out 0011 held afterwards.
- btn_Up=0 with stop_Up=0 → moving stays 0, position unchanged; release stop_Up → motion resumes within 3 clk + DIV.
- btn_Up and btn_Down both 0 → IDLE, no steps for 50 clk.
- half_mode=1 (macro defined), 8 up-ticks from index 0 → full 8-entry sequence, position +8; macro undefined → full-step sequence only.
- Assert rst_n=0 mid-interval → step_out 0000, position 0 same cycle; HOLD_EN=0 run → step_out 0000 whenever moving=0.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and helpers for the stepper axis controller.
// Phase tables, FSM state enum and step-rate divider computation.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  function automatic int calc_div(
    input int clk_hz,
    input int step_hz
  );
    return clk_hz / step_hz;
  endfunction

  function automatic logic [3:0] full_phase(
    input logic [1:0] i
  );
    logic [3:0] p;
    case (i)
      2'd0:    p = 4'b1100;
      2'd1:    p = 4'b0110;
      2'd2:    p = 4'b0011;
      2'd3:    p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] half_phase(
    input logic [2:0] i
  );
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      3'd7:    p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Reset value is a parameter so idle-high active-low inputs reset inactive.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stepper_axis_ctrl.sv
// Stepper axis controller: jog FSM, step-rate divider, phase sequencer.
// Define STEPPER_HALFSTEP_EN to compile in half-step mode support.
module stepper_axis_ctrl
  import stepper_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 500,
  parameter int POS_W   = 16,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_Up,
  input  logic             btn_Down,
  input  logic             stop_Up,
  input  logic             stop_Down,
  input  logic             half_mode,
  output logic [3:0]       step_out,
  output logic             moving,
  output logic             dir,
  output logic [POS_W-1:0] position
);

  localparam int DIV = calc_div(CLK_HZ, STEP_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef STEPPER_HALFSTEP_EN
  localparam int IW  = 3;
`else
  localparam int IW  = 2;
`endif

  localparam logic [CW-1:0]    CNT_ONE = 1;
  localparam logic [CW-1:0]    CNT_TOP = CW'(DIV - 1);
  localparam logic [IW-1:0]    IDX_ONE = 1;
  localparam logic [POS_W-1:0] POS_ONE = 1;

  logic up_n, dn_n, lu_n, ld_n;
  logic up_req, dn_req, lim_up, lim_dn;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_up (
    .clk(clk), .rst_n(rst_n), .d(btn_Up), .q(up_n)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_dn (
    .clk(clk), .rst_n(rst_n), .d(btn_Down), .q(dn_n)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_lu (
    .clk(clk), .rst_n(rst_n), .d(stop_Up), .q(lu_n)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_ld (
    .clk(clk), .rst_n(rst_n), .d(stop_Down), .q(ld_n)
  );

  assign up_req = ~up_n;
  assign dn_req = ~dn_n;
  assign lim_up = ~lu_n;
  assign lim_dn = ~ld_n;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, idx_nxt;
  logic [3:0]    phase_nxt;
  logic          tick;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (up_req && !dn_req && !lim_up)
          state_nxt = UP;
        else if (dn_req && !up_req && !lim_dn)
          state_nxt = DOWN;
      end
      UP: begin
        if (!up_req || dn_req || lim_up)
          state_nxt = IDLE;
      end
      DOWN: begin
        if (!dn_req || up_req || lim_dn)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tick is dropped when the FSM is leaving motion this cycle
  assign tick = (state != IDLE) && (state_nxt == state)
              && (cnt == CNT_TOP);

`ifdef STEPPER_HALFSTEP_EN
  logic mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mode_q <= 1'b0;
    else if (state == IDLE)
      mode_q <= half_mode;
  end

  // Remap keeps the coils near the same angle across a mode switch
  always_comb begin
    idx_nxt = idx;
    if (state == IDLE) begin
      if (half_mode && !mode_q)
        idx_nxt = {idx[1:0], 1'b1};
      else if (!half_mode && mode_q)
        idx_nxt = idx >> 1;
    end else if (tick) begin
      idx_nxt = (state == UP) ? idx + IDX_ONE : idx - IDX_ONE;
      if (!mode_q)
        idx_nxt[2] = 1'b0;
    end
  end

  assign phase_nxt = mode_q ? half_phase(idx_nxt)
                            : full_phase(idx_nxt[1:0]);
`else
  logic unused_half;
  assign unused_half = half_mode;

  always_comb begin
    idx_nxt = idx;
    if (tick)
      idx_nxt = (state == UP) ? idx + IDX_ONE : idx - IDX_ONE;
  end

  assign phase_nxt = full_phase(idx_nxt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      position <= '0;
      step_out <= 4'b0000;
      moving   <= 1'b0;
      dir      <= 1'b1;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      moving <= (state_nxt != IDLE);
      if (state_nxt == UP)
        dir <= 1'b1;
      else if (state_nxt == DOWN)
        dir <= 1'b0;
      if (state == IDLE || state_nxt != state || tick)
        cnt <= '0;
      else
        cnt <= cnt + CNT_ONE;
      if (tick) begin
        position <= (state == UP) ? position + POS_ONE
                                  : position - POS_ONE;
        step_out <= phase_nxt;
      end else if (!HOLD_EN && state_nxt == IDLE) begin
        step_out <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Scoreboard bench for stepper_axis_ctrl (DIV=10, POS_W=8).
// Step events are popped from a queue by a negedge monitor.
module tb_stepper_axis_ctrl;

  localparam int POS_W = 8;

  typedef struct packed {
    logic [3:0]       step;
    logic [POS_W-1:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b1;
  logic btn_dn = 1'b1;
  logic stop_up = 1'b1;
  logic stop_dn = 1'b1;
  logic half_mode = 1'b0;

  logic [3:0]       step_out, step_out_nh;
  logic             moving, moving_nh;
  logic             dir, dir_nh;
  logic [POS_W-1:0] position, position_nh;

  exp_t             exp_q[$];
  exp_t             e_m;
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               mon_en = 1'b0;
  logic [3:0]       prev_step;
  logic [POS_W-1:0] prev_pos;

  always #5 clk = ~clk;

  stepper_axis_ctrl #(
    .CLK_HZ(1000), .STEP_HZ(100), .POS_W(POS_W), .HOLD_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_Up(btn_up), .btn_Down(btn_dn),
    .stop_Up(stop_up), .stop_Down(stop_dn),
    .half_mode(half_mode),
    .step_out(step_out), .moving(moving),
    .dir(dir), .position(position)
  );

  stepper_axis_ctrl #(
    .CLK_HZ(1000), .STEP_HZ(100), .POS_W(POS_W), .HOLD_EN(1'b0)
  ) dut_nh (
    .clk(clk), .rst_n(rst_n),
    .btn_Up(btn_up), .btn_Down(btn_dn),
    .stop_Up(stop_up), .stop_Down(stop_dn),
    .half_mode(half_mode),
    .step_out(step_out_nh), .moving(moving_nh),
    .dir(dir_nh), .position(position_nh)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s,
                      input logic [POS_W-1:0] p);
    exp_q.push_back({s, p});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && (step_out !== prev_step || position !== prev_pos)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL step_event: unexpected step_out=%b position=%0d",
                   step_out, position);
        end else begin
          e_m = exp_q.pop_front();
          if ({step_out, position} !== e_m) begin
            n_bad++;
            $display("FAIL step_event: got %b/%0d expected %b/%0d",
                     step_out, position, e_m.step, e_m.pos);
          end
        end
      end
      if (mon_en && !moving_nh) begin
        n_cmp++;
        if (step_out_nh !== 4'b0000) begin
          n_bad++;
          $display("FAIL nohold_idle: got %b expected 0000", step_out_nh);
        end
      end
      prev_step = step_out;
      prev_pos  = position;
    end
  end

  initial begin
    int  first_seen;
    bit  saw_move;

    cycles(3);
    check("rst_step_out", 32'(step_out), 32'h0);
    check("rst_position", 32'(position), 32'h0);
    check("rst_moving", 32'(moving), 32'h0);
    check("rst_dir", 32'(dir), 32'h1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cycles(2);

    // jog up 45 clk: four full steps
    push(4'b0110, 8'd1);
    push(4'b0011, 8'd2);
    push(4'b1001, 8'd3);
    push(4'b1100, 8'd4);
    btn_up = 1'b0;
    cycles(45);
    btn_up = 1'b1;
    check("up_moving", 32'(moving), 32'h1);
    cycles(10);
    check("up_idle", 32'(moving), 32'h0);
    check("up_pos", 32'(position), 32'd4);
    check("up_dir", 32'(dir), 32'h1);
    check("up_hold", 32'(step_out), 32'b1100);
    check("nh_pos", 32'(position_nh), 32'd4);

    // jog down 25 clk: two steps back
    push(4'b1001, 8'd3);
    push(4'b0011, 8'd2);
    btn_dn = 1'b0;
    cycles(25);
    btn_dn = 1'b1;
    cycles(30);
    check("dn_dir", 32'(dir), 32'h0);
    check("dn_pos", 32'(position), 32'd2);
    check("dn_hold", 32'(step_out), 32'b0011);

    // upper limit blocks motion, release resumes
    stop_up = 1'b0;
    cycles(5);
    btn_up = 1'b0;
    saw_move = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (moving) saw_move = 1'b1;
    end
    check("lim_no_move", 32'(saw_move), 32'h0);
    check("lim_pos", 32'(position), 32'd2);
    push(4'b1001, 8'd3);
    push(4'b1100, 8'd4);
    stop_up = 1'b1;
    first_seen = -1;
    for (int i = 0; i < 25; i++) begin
      cycles(1);
      if (moving && first_seen < 0) first_seen = i + 1;
    end
    btn_up = 1'b1;
    cycles(10);
    check("lim_resume_lat", 32'(first_seen), 32'd3);
    check("lim_resume_pos", 32'(position), 32'd4);

    // both buttons: no motion
    btn_up = 1'b0;
    btn_dn = 1'b0;
    saw_move = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (moving) saw_move = 1'b1;
    end
    btn_up = 1'b1;
    btn_dn = 1'b1;
    cycles(5);
    check("both_no_move", 32'(saw_move), 32'h0);
    check("both_pos", 32'(position), 32'd4);

    // eight up-ticks with half_mode requested
    half_mode = 1'b1;
    cycles(3);
`ifdef STEPPER_HALFSTEP_EN
    push(4'b0100, 8'd5);
    push(4'b0110, 8'd6);
    push(4'b0010, 8'd7);
    push(4'b0011, 8'd8);
    push(4'b0001, 8'd9);
    push(4'b1001, 8'd10);
    push(4'b1000, 8'd11);
    push(4'b1100, 8'd12);
`else
    push(4'b0110, 8'd5);
    push(4'b0011, 8'd6);
    push(4'b1001, 8'd7);
    push(4'b1100, 8'd8);
    push(4'b0110, 8'd9);
    push(4'b0011, 8'd10);
    push(4'b1001, 8'd11);
    push(4'b1100, 8'd12);
`endif
    btn_up = 1'b0;
    cycles(85);
    btn_up = 1'b1;
    cycles(10);
    half_mode = 1'b0;
    cycles(3);
    check("half_pos", 32'(position), 32'd12);
    check("half_hold", 32'(step_out), 32'b1100);

    // asynchronous reset in the middle of an interval
    push(4'b0110, 8'd13);
    push(4'b0000, 8'd0);
    btn_up = 1'b0;
    cycles(18);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_step_out", 32'(step_out), 32'h0);
    check("arst_position", 32'(position), 32'h0);
    check("arst_moving", 32'(moving), 32'h0);
    check("arst_dir", 32'(dir), 32'h1);
    check("arst_nh_pos", 32'(position_nh), 32'h0);
    btn_up = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check("post_rst_pos", 32'(position), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
